reg_file_param: RTL and testbench

//  Parametrised integer register file for the RISC-V core. Replaces the fixed 32x32, 2-read design.

---
 rtl/regfile_pkg.sv | 30 +++
 rtl/regfile_clr_seq.sv | 73 +++++++
 rtl/reg_file_param.sv | 96 +++++++++
 tb/tb_reg_file_param.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// ============================================================================
// Module      : regfile_pkg
// Description : Shared defaults, clear-FSM state encoding and clog2 helper for
//               the parametrised integer register file.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package regfile_pkg;

    localparam int DW_DEFAULT    = 32;
    localparam int DEPTH_DEFAULT = 32;
    localparam int NRD_DEFAULT   = 2;

    typedef logic [0:0] state_t;
    localparam state_t ST_IDLE  = 1'b0;
    localparam state_t ST_CLEAR = 1'b1;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) r = i + 1;
        end
        return r;
    endfunction

endpackage

`default_nettype wire

// File: rtl/regfile_clr_seq.sv
// ============================================================================
// Module      : regfile_clr_seq
// Description : Sequenced bulk-clear engine; sweeps ptr across the register
//               file issuing one zero-write per cycle.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module regfile_clr_seq
    import regfile_pkg::*;
#(
    parameter  int DEPTH    = DEPTH_DEFAULT,
    parameter  int ZERO_REG = 1,
    localparam int AW       = clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr_req,
    output logic          clr_busy,
    output logic          clr_we,
    output logic [AW-1:0] clr_addr
);

    // With a hardwired x0 the sweep skips register 0 entirely.
    localparam logic [AW-1:0] c_START = (ZERO_REG != 0) ? AW'(1) : '0;
    localparam logic [AW-1:0] c_LAST  = AW'(DEPTH - 1);
    localparam logic [AW-1:0] c_ONE   = AW'(1);

    state_t        r_state;
    state_t        w_state_nxt;
    logic [AW-1:0] r_ptr;
    logic [AW-1:0] w_ptr_nxt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
            r_ptr   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_ptr   <= w_ptr_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_ptr_nxt   = r_ptr;
        case (r_state)
            ST_IDLE: begin
                if (clr_req) begin
                    w_state_nxt = ST_CLEAR;
                    w_ptr_nxt   = c_START;
                end
            end
            ST_CLEAR: begin
                if (r_ptr == c_LAST) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_ptr_nxt = r_ptr + c_ONE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        clr_busy = (r_state == ST_CLEAR);
        clr_we   = (r_state == ST_CLEAR);
        clr_addr = r_ptr;
    end

endmodule

`default_nettype wire

// File: rtl/reg_file_param.sv
// ============================================================================
// Module      : reg_file_param
// Description : Parametrised integer register file with combinational read
//               ports, optional hardwired x0, bulk-clear engine and debug tap.
//               Optional write-through forwarding: define REGFILE_BYPASS_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module reg_file_param
    import regfile_pkg::*;
#(
    parameter  int DW       = DW_DEFAULT,
    parameter  int DEPTH    = DEPTH_DEFAULT,
    parameter  int NRD      = NRD_DEFAULT,
    parameter  int ZERO_REG = 1,
    parameter  int DBG_IDX  = 8,
    localparam int AW       = clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NRD*AW-1:0] rd_addr,
    output logic [NRD*DW-1:0] rd_data,
    input  logic              wr_en,
    input  logic [AW-1:0]     wr_addr,
    input  logic [DW-1:0]     wr_data,
    input  logic              clr_req,
    output logic              clr_busy,
    output logic [DW-1:0]     dbg_data
);

    localparam logic [AW-1:0] c_DBG_ADDR = AW'(DBG_IDX);

    logic [DW-1:0] r_mem [DEPTH];
    logic          w_clr_busy;
    logic          w_clr_we;
    logic [AW-1:0] w_clr_addr;
    logic          w_wr_zero;
    logic          w_usr_we;

    regfile_clr_seq #(
        .DEPTH    (DEPTH),
        .ZERO_REG (ZERO_REG)
    ) u_clr_seq (
        .clk      (clk),
        .rst      (rst),
        .clr_req  (clr_req),
        .clr_busy (w_clr_busy),
        .clr_we   (w_clr_we),
        .clr_addr (w_clr_addr)
    );

    assign clr_busy  = w_clr_busy;
    assign w_wr_zero = (ZERO_REG != 0) && (wr_addr == '0);
    // User writes are dropped, not deferred, while the sweep owns the port.
    assign w_usr_we  = wr_en && !w_clr_busy && !w_wr_zero;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_clr_we) begin
            r_mem[w_clr_addr] <= '0;
        end else if (w_usr_we) begin
            r_mem[wr_addr] <= wr_data;
        end
    end

    for (genvar gi = 0; gi < NRD; gi++) begin : g_rd
        logic [AW-1:0] w_addr;
        logic          w_zero;
        logic          w_fwd;
        assign w_addr = rd_addr[gi*AW +: AW];
        assign w_zero = (ZERO_REG != 0) && (w_addr == '0);
`ifdef REGFILE_BYPASS_EN
        assign w_fwd  = w_usr_we && (w_addr == wr_addr);
`else
        assign w_fwd  = 1'b0;
`endif
        assign rd_data[gi*DW +: DW] = w_zero ? '0 : (w_fwd ? wr_data : r_mem[w_addr]);
    end

    logic w_dbg_zero;
    logic w_dbg_fwd;
    assign w_dbg_zero = (ZERO_REG != 0) && (c_DBG_ADDR == '0);
`ifdef REGFILE_BYPASS_EN
    assign w_dbg_fwd  = w_usr_we && (c_DBG_ADDR == wr_addr);
`else
    assign w_dbg_fwd  = 1'b0;
`endif
    assign dbg_data = w_dbg_zero ? '0 : (w_dbg_fwd ? wr_data : r_mem[c_DBG_ADDR]);

endmodule

`default_nettype wire

// File: tb/tb_reg_file_param.sv
// ============================================================================
// Module      : tb_reg_file_param
// Description : Self-checking bench for reg_file_param; default and
//               DEPTH=16/NRD=3/ZERO_REG=0/DBG_IDX=2 instances vs. array model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_reg_file_param;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #50 clk = ~clk;

    logic [9:0]  a_rd_addr = '0;
    logic [63:0] a_rd_data;
    logic        a_wr_en = 1'b0;
    logic [4:0]  a_wr_addr = '0;
    logic [31:0] a_wr_data = '0;
    logic        a_clr_req = 1'b0;
    logic        a_clr_busy;
    logic [31:0] a_dbg;

    logic [11:0] b_rd_addr = '0;
    logic [95:0] b_rd_data;
    logic        b_wr_en = 1'b0;
    logic [3:0]  b_wr_addr = '0;
    logic [31:0] b_wr_data = '0;
    logic        b_clr_req = 1'b0;
    logic        b_clr_busy;
    logic [31:0] b_dbg;

    reg_file_param u_dut_a (
        .clk      (clk),
        .rst      (rst),
        .rd_addr  (a_rd_addr),
        .rd_data  (a_rd_data),
        .wr_en    (a_wr_en),
        .wr_addr  (a_wr_addr),
        .wr_data  (a_wr_data),
        .clr_req  (a_clr_req),
        .clr_busy (a_clr_busy),
        .dbg_data (a_dbg)
    );

    reg_file_param #(
        .DW       (32),
        .DEPTH    (16),
        .NRD      (3),
        .ZERO_REG (0),
        .DBG_IDX  (2)
    ) u_dut_b (
        .clk      (clk),
        .rst      (rst),
        .rd_addr  (b_rd_addr),
        .rd_data  (b_rd_data),
        .wr_en    (b_wr_en),
        .wr_addr  (b_wr_addr),
        .wr_data  (b_wr_data),
        .clr_req  (b_clr_req),
        .clr_busy (b_clr_busy),
        .dbg_data (b_dbg)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    endtask

    // Reference: plain arrays plus a queue of register indices still to be cleared.
    logic [31:0] ma [32];
    logic [31:0] mb [16];
    int qa[$];
    int qb[$];

    function automatic logic [31:0] exp_a(input logic [4:0] ad);
        if (ad == 5'd0) return 32'h0;
`ifdef REGFILE_BYPASS_EN
        if (a_wr_en && qa.size() == 0 && ad == a_wr_addr) return a_wr_data;
`endif
        return ma[ad];
    endfunction

    function automatic logic [31:0] exp_b(input logic [3:0] ad);
`ifdef REGFILE_BYPASS_EN
        if (b_wr_en && qb.size() == 0 && ad == b_wr_addr) return b_wr_data;
`endif
        return mb[ad];
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 32; i++) ma[i] = '0;
        for (int i = 0; i < 16; i++) mb[i] = '0;
        qa.delete();
        qb.delete();
    endtask

    task automatic model_edge();
        if (qa.size() != 0) begin
            ma[qa.pop_front()] = '0;
        end else begin
            if (a_wr_en && a_wr_addr != 5'd0) ma[a_wr_addr] = a_wr_data;
            if (a_clr_req) for (int i = 1; i < 32; i++) qa.push_back(i);
        end
        if (qb.size() != 0) begin
            mb[qb.pop_front()] = '0;
        end else begin
            if (b_wr_en) mb[b_wr_addr] = b_wr_data;
            if (b_clr_req) for (int i = 0; i < 16; i++) qb.push_back(i);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        if (rst) model_edge();
        #1;
    endtask

    task automatic compare_all(input string tag);
        #1;
        for (int p = 0; p < 2; p++)
            check($sformatf("%s a.rd%0d", tag, p), a_rd_data[p*32 +: 32], exp_a(a_rd_addr[p*5 +: 5]));
        check({tag, " a.dbg"}, a_dbg, exp_a(5'd8));
        check({tag, " a.busy"}, 32'(a_clr_busy), 32'(qa.size() != 0));
        for (int p = 0; p < 3; p++)
            check($sformatf("%s b.rd%0d", tag, p), b_rd_data[p*32 +: 32], exp_b(b_rd_addr[p*4 +: 4]));
        check({tag, " b.dbg"}, b_dbg, exp_b(4'd2));
        check({tag, " b.busy"}, 32'(b_clr_busy), 32'(qb.size() != 0));
    endtask

    // Must start right after tick(): sweeps every address well inside one cycle.
    task automatic read_all(input string tag);
        a_wr_en = 1'b0;
        b_wr_en = 1'b0;
        for (int i = 0; i < 32; i++) begin
            a_rd_addr = {5'(31 - i), 5'(i)};
            b_rd_addr = {4'((i + 9) % 16), 4'((i + 5) % 16), 4'(i % 16)};
            compare_all($sformatf("%s[%0d]", tag, i));
        end
    endtask

    task automatic sweep_len(input string tag);
        int na;
        int nb;
        na = 0;
        nb = 0;
        a_clr_req = 1'b1;
        b_clr_req = 1'b1;
        compare_all({tag, " req"});
        tick();
        a_clr_req = 1'b0;
        b_clr_req = 1'b0;
        for (int k = 0; k < 100; k++) begin
            if (!a_clr_busy && !b_clr_busy) break;
            na += 32'(a_clr_busy);
            nb += 32'(b_clr_busy);
            a_wr_en   = (k == 15);
            a_wr_addr = 5'd3;
            a_wr_data = 32'h55;
            a_rd_addr = 10'($urandom);
            b_rd_addr = 12'($urandom);
            compare_all($sformatf("%s cyc%0d", tag, k));
            tick();
        end
        a_wr_en = 1'b0;
        check({tag, " a.busy_cycles"}, 32'(na), 32'd31);
        check({tag, " b.busy_cycles"}, 32'(nb), 32'd16);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        model_reset();
        // T1: power-on reset, then reset after random traffic
        #20;
        compare_all("t1_por");
        #10 rst = 1'b1;
        tick();
        for (int i = 0; i < 40; i++) begin
            a_wr_en = 1'b1; a_wr_addr = 5'($urandom); a_wr_data = $urandom;
            b_wr_en = 1'b1; b_wr_addr = 4'($urandom); b_wr_data = $urandom;
            a_rd_addr = 10'($urandom); b_rd_addr = 12'($urandom);
            compare_all("t1_fill");
            tick();
        end
        a_wr_en = 1'b0; b_wr_en = 1'b0;
        rst = 1'b0;
        model_reset();
        read_all("t1_reset");
        #5 rst = 1'b1;
        tick();

        // T2: basic write/read, x0 write discarded, B's r0 writable
        a_wr_en = 1'b1; a_wr_addr = 5'd5; a_wr_data = 32'hDEADBEEF;
        b_wr_en = 1'b1; b_wr_addr = 4'd0; b_wr_data = 32'hCAFE0000;
        compare_all("t2_w1");
        tick();
        a_wr_addr = 5'd0; a_wr_data = 32'h1234;
        b_wr_addr = 4'd2; b_wr_data = 32'h22222222;
        a_rd_addr = {5'd9, 5'd5};
        compare_all("t2_w2");
        check("t2_r5", a_rd_data[31:0], 32'hDEADBEEF);
        tick();
        a_wr_en = 1'b0; b_wr_en = 1'b0;
        a_rd_addr = {5'd5, 5'd0};
        b_rd_addr = {4'd5, 4'd2, 4'd0};
        compare_all("t2_rd");
        check("t2_r0", a_rd_data[31:0], 32'h0);
        check("t6_b_r0", b_rd_data[31:0], 32'hCAFE0000);
        check("t6_b_dbg", b_dbg, 32'h22222222);

        // T3: same-cycle write and read of r7
        a_wr_en = 1'b1; a_wr_addr = 5'd7; a_wr_data = 32'hA5A5A5A5;
        a_rd_addr = {5'd7, 5'd5};
        compare_all("t3_same");
`ifdef REGFILE_BYPASS_EN
        check("t3_same_port1", a_rd_data[63:32], 32'hA5A5A5A5);
`else
        check("t3_same_port1", a_rd_data[63:32], ma[7]);
`endif
        tick();
        a_wr_en = 1'b0;
        compare_all("t3_next");
        check("t3_next_port1", a_rd_data[63:32], 32'hA5A5A5A5);

        // T4: fill with index values, sweep, mid-sweep write dropped
        for (int i = 0; i < 32; i++) begin
            a_wr_en = 1'b1; a_wr_addr = 5'(i); a_wr_data = 32'(i);
            b_wr_en = (i < 16); b_wr_addr = 4'(i); b_wr_data = 32'(i);
            a_rd_addr = 10'($urandom); b_rd_addr = 12'($urandom);
            compare_all("t4_fill");
            tick();
        end
        a_wr_en = 1'b0; b_wr_en = 1'b0;
        sweep_len("t4");
        read_all("t4_after");
        tick();
        a_rd_addr = {5'd8, 5'd3};
        compare_all("t4_r3");
        check("t4_r3_zero", a_rd_data[31:0], 32'h0);

        // T5: reset at sweep cycle 10, then a fresh full sweep
        for (int i = 1; i < 16; i++) begin
            a_wr_en = 1'b1; a_wr_addr = 5'(i); a_wr_data = $urandom;
            b_wr_en = 1'b1; b_wr_addr = 4'(i); b_wr_data = $urandom;
            tick();
        end
        a_wr_en = 1'b0; b_wr_en = 1'b0;
        a_clr_req = 1'b1; b_clr_req = 1'b1;
        tick();
        a_clr_req = 1'b0; b_clr_req = 1'b0;
        repeat (10) begin
            compare_all("t5_pre");
            tick();
        end
        #3 rst = 1'b0;
        model_reset();
        #1;
        check("t5_a_busy_now", 32'(a_clr_busy), 32'd0);
        check("t5_b_busy_now", 32'(b_clr_busy), 32'd0);
        read_all("t5_reset");
        #5 rst = 1'b1;
        tick();
        sweep_len("t5_again");

        // Randomized traffic with occasional clear requests
        for (int c = 0; c < 400; c++) begin
            a_wr_en = 1'($urandom); a_wr_addr = 5'($urandom); a_wr_data = $urandom;
            b_wr_en = 1'($urandom); b_wr_addr = 4'($urandom); b_wr_data = $urandom;
            a_clr_req = ($urandom_range(0, 39) == 0);
            b_clr_req = ($urandom_range(0, 39) == 0);
            a_rd_addr = 10'($urandom); b_rd_addr = 12'($urandom);
            compare_all($sformatf("rand%0d", c));
            tick();
        end
        a_wr_en = 1'b0; b_wr_en = 1'b0; a_clr_req = 1'b0; b_clr_req = 1'b0;
        repeat (40) tick();
        read_all("final");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
